blk_stage3_deser: RTL and testbench
===================================

// Module: blk_stage3_deser
// PURPOSE
//  Downstream neighbour of the two-stage capture path: consumes the serial bit stream
//  registered out of blk_stage2 (its `out` flop), hunts for a sync pattern, then packs
//  aligned WIDTH-bit words into a small output FIFO with a valid/ready handshake.
//  Single clock domain, synchronous active-high reset.
// PARAMETERS
//  WIDTH         8      word width and bits per frame; >= 2
//  SYNC_PATTERN  8'hA5  WIDTH-bit alignment pattern, MSB received first
//  DEPTH         2      output FIFO entries; power of two, >= 2
//  CNT_W         8      width of saturating drop counter
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_bit       in   1      serial data from upstream stage output flop
//  in_en        in   1      in_bit is a valid sample this cycle
//  resync       in   1      pulse: abandon alignment, return to HUNT
//  word_data    out  WIDTH  FIFO head word, MSB = first received bit
//  word_valid   out  1      FIFO non-empty
//  word_ready   in   1      consumer accepts head when word_valid & word_ready
//  locked       out  1      FSM in LOCKED
//  overflow     out  1      sticky: a word was dropped (cleared only by rst)
//  drop_count   out  CNT_W  dropped words, saturates at all-ones
// BEHAVIOUR
//  - Reset: word_data=0, word_valid=0, locked=0, overflow=0, drop_count=0;
//    FSM=HUNT, shift reg=0, bit counter=0, FIFO empty. Reset mid-frame discards partial word.
//  - Bits sampled only when in_en=1; in_en=0 cycles freeze shift reg and counter.
//  - HUNT: shift reg <= {shift[WIDTH-2:0], in_bit}. If the updated value == SYNC_PATTERN,
//    go LOCKED next cycle, bit counter=0; the sync word itself is never pushed.
//    Before WIDTH bits accepted since reset/resync, no match is possible (fill counter).
//  - LOCKED: shift in bits; counter counts 0..WIDTH-1. On the WIDTH-th bit (counter==WIDTH-1)
//    the completed word is pushed, counter wraps to 0. A word equal to SYNC_PATTERN while
//    LOCKED is ordinary data; no realignment.
//  - resync=1: FSM=HUNT, shift reg and counters cleared, that cycle's in_bit discarded
//    (resync beats in_en). FIFO contents and overflow/drop_count unaffected.
//  - Latency: word_valid rises the cycle after the clock edge that accepts the last bit
//    (registered push), FIFO empty case.
//  - FIFO: pop when word_valid & word_ready. Push when full and no pop that cycle: word
//    dropped, overflow<=1, drop_count+1 (hold at max). Push+pop same cycle when full: both
//    succeed, count unchanged. Push+pop when empty: push only (no fall-through).
//  - word_data holds stable while word_valid=1 and word_ready=0; 0 when empty is not
//    required (don't-care), but reset value is 0.
//  - Pointers wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
// STRUCTURE
//  - Package deser_pkg: state typedef {HUNT, LOCKED}; default WIDTH/SYNC constants.
//  - One sub-module: deser_fifo (WIDTH, DEPTH) with push/pop/full/empty/head; drop logic
//    and counters stay in the top. FSM + shift reg + bit counter in the top module.
// TESTING
//  1. rst, then bits 1010_0101 then 0011_1100 (in_en=1) -> locked=1 after 8th bit,
//     word_data=8'h3C, word_valid=1 one cycle after 16th bit; A5 not output.
//  2. LOCKED, stream 8'hA5 as data with word_ready=1 -> word 8'hA5 delivered, locked stays 1.
//  3. word_ready=0, push 3 words (DEPTH=2) -> 3rd dropped, overflow=1, drop_count=1,
//     head still first word; then ready=1 drains exactly 2 words in order.
//  4. FIFO full, word completes same cycle as pop -> no drop, drop_count unchanged.
//  5. resync mid-frame after 3 bits -> locked=0 next cycle, partial bits discarded;
//     relock requires full A5; queued words still drain.
//  6. in_en toggling 1/0 across a frame, then rst mid-frame -> word correct despite gaps;
//     after rst all outputs 0 and HUNT.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and default constants for the stage-3 deserializer slice.
// Consumed by the top module and its bench.
package deser_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int unsigned DEF_WIDTH = 8;
   localparam logic [7:0]  DEF_SYNC  = 8'hA5;
   localparam int unsigned DEF_DEPTH = 2;
   localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/blk_stage3_deser_if.sv
// Output word handshake bundle: the deserializer is the master (it produces data/valid),
// and the consumer is the slave (it drives ready).
interface blk_stage3_deser_if #(
   parameter int unsigned WIDTH = 8
);

   logic [WIDTH-1:0] word_data;
   logic             word_valid;
   logic             word_ready;

   modport master (
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/deser_fifo.sv
// Small synchronous FIFO with a registered write and a combinational head (no fall-through).
// A push into a full FIFO is honoured only when a pop happens on the same edge.
module deser_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // When full, wr_ptr == rd_ptr: the popped slot is rewritten on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/blk_stage3_deser.sv
// Serial-to-parallel stage: hunts for a sync word on the upstream bit stream, then packs
// aligned words into a small FIFO; dropped words are flagged and counted.
module blk_stage3_deser
   import deser_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC),
   parameter int unsigned      DEPTH        = DEF_DEPTH,
   parameter int unsigned      CNT_W        = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_bit,
   input  logic                in_en,
   input  logic                resync,
   blk_stage3_deser_if.master  word,
   output logic                locked,
   output logic                overflow,
   output logic [CNT_W-1:0]    drop_count
);

   localparam int unsigned      BW   = $clog2(WIDTH + 1);
   localparam logic [BW-1:0]    LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0]    FILL = BW'(WIDTH);

   state_t           state;
   state_t           state_n;
   // Only WIDTH-1 history bits are kept; the newest bit completes the word combinationally.
   logic [WIDTH-2:0] shift;
   logic [WIDTH-2:0] shift_n;
   logic [WIDTH-1:0] shifted;
   logic [BW-1:0]    cnt;
   logic [BW-1:0]    cnt_n;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         shift <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         shift <= shift_n;
         cnt   <= cnt_n;
      end
   end

   // In HUNT, cnt is a saturating fill count so a match needs WIDTH real bits.
   always_comb begin
      state_n = state;
      shift_n = shift;
      cnt_n   = cnt;
      push    = 1'b0;
      shifted = {shift, in_bit};
      if (resync) begin
         state_n = HUNT;
         shift_n = '0;
         cnt_n   = '0;
      end else if (in_en) begin
         shift_n = shifted[WIDTH-2:0];
         unique case (state)
            HUNT: begin
               if ((cnt >= LAST) && (shifted == SYNC_PATTERN)) begin
                  state_n = LOCKED;
                  cnt_n   = '0;
               end else if (cnt != FILL) begin
                  cnt_n = cnt + BW'(1);
               end
            end
            LOCKED: begin
               if (cnt == LAST) begin
                  push  = 1'b1;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + BW'(1);
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign locked          = (state == LOCKED);
   assign word.word_valid = ~empty;
   assign pop             = ~empty & word.word_ready;
   assign drop            = push & full & ~pop;

   deser_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .data  (shifted),
      .full  (full),
      .empty (empty),
      .head  (word.word_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_blk_stage3_deser.sv
// Directed bench for blk_stage3_deser: sync hunt, packing, FIFO backpressure/drops,
// resync, in_en gaps and mid-frame reset.
module tb_blk_stage3_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_bit;
   logic       in_en;
   logic       resync;
   logic       locked;
   logic       overflow;
   logic [7:0] drop_count;
   int         checks   = 0;
   int         failures = 0;

   blk_stage3_deser_if #(.WIDTH(8)) bus ();

   blk_stage3_deser #(
      .WIDTH        (8),
      .SYNC_PATTERN (8'hA5),
      .DEPTH        (2),
      .CNT_W        (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_bit     (in_bit),
      .in_en      (in_en),
      .resync     (resync),
      .word       (bus),
      .locked     (locked),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      in_bit = b;
      in_en  = 1'b1;
      tick();
      in_en  = 1'b0;
      in_bit = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset_sync();
      logic [7:0] sync = 8'hA5;
      do_reset();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0b want=0", locked); end
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b want=0", bus.word_valid); end
      checks++; if (bus.word_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h want=00", bus.word_data); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0b/%0d want=0/0", overflow, drop_count); end
      for (int i = 7; i >= 1; i--) send_bit(sync[i]);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sync_7bits_locked got=%0b want=0", locked); end
      send_bit(sync[0]);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sync_locked got=%0b want=1", locked); end
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL sync_not_pushed got=%0b want=0", bus.word_valid); end
      for (int i = 0; i < 7; i++) send_bit((8'h3C >> (7 - i)) & 1'b1);
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL word1_early got=%0b want=0", bus.word_valid); end
      send_bit(1'b0);
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h3C) begin failures++; $display("FAIL word1 got=%0b/%h want=1/3c", bus.word_valid, bus.word_data); end
      bus.word_ready = 1'b1;
      tick();
      bus.word_ready = 1'b0;
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL word1_only got=%0b want=0", bus.word_valid); end
   endtask

   task automatic test_sync_as_data();
      bus.word_ready = 1'b1;
      send_byte(8'hA5);
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hA5) begin failures++; $display("FAIL a5_data got=%0b/%h want=1/a5", bus.word_valid, bus.word_data); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL a5_locked got=%0b want=1", locked); end
      tick();
      bus.word_ready = 1'b0;
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL a5_drained got=%0b want=0", bus.word_valid); end
   endtask

   task automatic test_overflow();
      send_byte(8'h11);
      send_byte(8'h22);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%0b want=0", overflow); end
      send_byte(8'h33);
      checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin failures++; $display("FAIL ovf_drop got=%0b/%0d want=1/1", overflow, drop_count); end
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h11) begin failures++; $display("FAIL ovf_head got=%0b/%h want=1/11", bus.word_valid, bus.word_data); end
      bus.word_ready = 1'b1;
      tick();
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h22) begin failures++; $display("FAIL ovf_second got=%0b/%h want=1/22", bus.word_valid, bus.word_data); end
      tick();
      bus.word_ready = 1'b0;
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b want=0", bus.word_valid); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] w = 8'h66;
      send_byte(8'h44);
      send_byte(8'h55);
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      bus.word_ready = 1'b1;
      send_bit(w[0]);
      bus.word_ready = 1'b0;
      checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) begin failures++; $display("FAIL pp_nodrop got=%0b/%0d want=1/1", overflow, drop_count); end
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h55) begin failures++; $display("FAIL pp_head got=%0b/%h want=1/55", bus.word_valid, bus.word_data); end
      bus.word_ready = 1'b1;
      tick();
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h66) begin failures++; $display("FAIL pp_third got=%0b/%h want=1/66", bus.word_valid, bus.word_data); end
      tick();
      bus.word_ready = 1'b0;
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%0b want=0", bus.word_valid); end
   endtask

   task automatic test_resync();
      // Pre-resync tail '1' plus the 7 bits below would spell A5 if history survived.
      logic [6:0] tail7 = 7'b0100101;
      send_byte(8'h77);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      resync = 1'b1;
      in_en  = 1'b1;
      in_bit = 1'b1;
      tick();
      resync = 1'b0;
      in_en  = 1'b0;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rs_unlock got=%0b want=0", locked); end
      for (int i = 6; i >= 0; i--) send_bit(tail7[i]);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rs_partial got=%0b want=0", locked); end
      send_bit(1'b0);
      send_byte(8'hA5);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rs_relock got=%0b want=1", locked); end
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h77) begin failures++; $display("FAIL rs_queued got=%0b/%h want=1/77", bus.word_valid, bus.word_data); end
      bus.word_ready = 1'b1;
      tick();
      bus.word_ready = 1'b0;
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL rs_drained got=%0b want=0", bus.word_valid); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 255; i++) send_byte(8'(i) ^ 8'h5A);
      checks++; if (drop_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d want=254", drop_count); end
      send_byte(8'h01);
      send_byte(8'h02);
      checks++; if (drop_count !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%0d want=255", drop_count); end
      checks++; if (bus.word_data !== 8'h5A) begin failures++; $display("FAIL sat_head got=%h want=5a", bus.word_data); end
      bus.word_ready = 1'b1;
      tick();
      checks++; if (bus.word_data !== 8'h5B) begin failures++; $display("FAIL sat_second got=%h want=5b", bus.word_data); end
      tick();
      bus.word_ready = 1'b0;
   endtask

   task automatic test_gaps_reset();
      logic [7:0] w = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         in_bit = ~w[i];
         tick();
         tick();
      end
      checks++; if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hC3) begin failures++; $display("FAIL gap_word got=%0b/%h want=1/c3", bus.word_valid, bus.word_data); end
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      do_reset();
      checks++; if (locked !== 1'b0 || bus.word_valid !== 1'b0 || bus.word_data !== 8'h00) begin failures++; $display("FAIL rst2_out got=%0b/%0b/%h want=0/0/00", locked, bus.word_valid, bus.word_data); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL rst2_drop got=%0b/%0d want=0/0", overflow, drop_count); end
      send_byte(8'h3C);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst2_hunt got=%0b want=0", locked); end
      send_byte(8'hA5);
      checks++; if (locked !== 1'b1 || bus.word_valid !== 1'b0) begin failures++; $display("FAIL rst2_relock got=%0b/%0b want=1/0", locked, bus.word_valid); end
   endtask

   initial begin
      rst            = 1'b1;
      in_bit         = 1'b0;
      in_en          = 1'b0;
      resync         = 1'b0;
      bus.word_ready = 1'b0;
      test_reset_sync();
      test_sync_as_data();
      test_overflow();
      test_push_pop_full();
      test_resync();
      test_saturate();
      test_gaps_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
